// File: rtl/binary_mul_seq_param_pkg.sv
// binary_mul_pkg: FSM state type and iteration-count helpers for the sequential multiplier
package binary_mul_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   function automatic int iter_f(input int width, input int bpc);
      return (width + bpc - 1) / bpc;
   endfunction
   function automatic int cnt_w_f(input int width, input int bpc);
      return $clog2(iter_f(width, bpc)) + 1;
   endfunction
endpackage

// File: rtl/binary_mul_seq_param_if.sv
// binary_mul_seq_param_if: operand/product valid-ready bundle for the sequential multiplier
interface binary_mul_seq_param_if #(parameter int WIDTH = 15);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               signed_mode;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] p;
   modport master(output in_valid, a, b, signed_mode, out_ready, input in_ready, out_valid, p);
   modport slave(input in_valid, a, b, signed_mode, out_ready, output in_ready, out_valid, p);
endinterface

// File: rtl/binary_mul_seq_param_pp_step.sv
// binary_mul_pp_step: adds one BPC-bit partial product, placed at its bit position, to the accumulator
module binary_mul_pp_step
   import binary_mul_pkg::*;
#(
   parameter int WIDTH = 15,
   parameter int BPC   = 1,
   parameter int CNT_W = cnt_w_f(15, 1)
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [BPC-1:0]     bits_i,
   input  logic [CNT_W-1:0]   step_i,
   output logic [2*WIDTH-1:0] acc_o
);
   logic [2*WIDTH-1:0] pp;
   always_comb begin
      pp    = (2*WIDTH)'(a_i) * (2*WIDTH)'(bits_i);
      acc_o = acc_i + (pp << (BPC * int'(step_i)));
   end
endmodule

// File: rtl/binary_mul_seq_param.sv
// binary_mul_seq_param: iterative signed/unsigned multiplier retiring BPC multiplier bits per enabled cycle
module binary_mul_seq_param
   import binary_mul_pkg::*;
#(
   parameter int WIDTH = 15,
   parameter int BPC   = 1
) (
   input logic clk,
   input logic rst,
   input logic en_i,
   binary_mul_seq_param_if.slave bus
);
   localparam int ITER  = iter_f(WIDTH, BPC);
   localparam int CNT_W = cnt_w_f(WIDTH, BPC);
   localparam int BW    = ITER * BPC;
   state_e             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [BW-1:0]      b_q;
   logic               neg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   step;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] p_q;
   logic               ov_q;
   logic               load;
   // Magnitude in WIDTH unsigned bits, so the most negative value maps onto 2^(WIDTH-1)
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic sm);
      return (sm && x[WIDTH-1]) ? -x : x;
   endfunction
   always_comb begin
      bus.in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
      load         = bus.in_valid & bus.in_ready;
      step         = CNT_W'(ITER - 1) - cnt_q;
   end
   assign bus.out_valid = ov_q;
   assign bus.p         = p_q;
   binary_mul_pp_step #(.WIDTH(WIDTH), .BPC(BPC), .CNT_W(CNT_W)) u_pp (
      .acc_i (acc_q),
      .a_i   (a_q),
      .bits_i(b_q[BPC-1:0]),
      .step_i(step),
      .acc_o (acc_d)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         ov_q    <= 1'b0;
      end else if (en_i) begin
         if (load) begin
            a_q     <= mag_f(bus.a, bus.signed_mode);
            b_q     <= BW'(mag_f(bus.b, bus.signed_mode));
            neg_q   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_q   <= '0;
            cnt_q   <= CNT_W'(ITER - 1);
            ov_q    <= 1'b0;
            state_q <= BUSY;
         end else if (state_q == BUSY) begin
            acc_q <= acc_d;
            b_q   <= b_q >> BPC;
            if (cnt_q == '0) begin
               p_q     <= neg_q ? -acc_d : acc_d;
               ov_q    <= 1'b1;
               state_q <= DONE;
            end else begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
         end else if (state_q == DONE && bus.out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_binary_mul_seq_param.sv
// tb_binary_mul_seq_param: scoreboard bench for the sequential multiplier across several WIDTH/BPC configurations
module tb_binary_mul_seq_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;
   int   nchk = 0;
   int   nerr = 0;
   always #5 clk = ~clk;

   binary_mul_seq_param_if #(15) m();
   binary_mul_seq_param_if #(15) m4();
   binary_mul_seq_param #(.WIDTH(15), .BPC(1)) d0(.clk(clk), .rst(rst), .en_i(en), .bus(m));
   binary_mul_seq_param #(.WIDTH(15), .BPC(4)) d1(.clk(clk), .rst(rst), .en_i(1'b1), .bus(m4));

   localparam int SW[4] = '{8, 16, 16, 15};
   localparam int SB[4] = '{2, 1, 4, 2};
   logic [15:0] s_a, s_b;
   logic        s_sm, s_valid;
   logic        s_ov[4];
   logic [31:0] s_p[4];
   generate
      for (genvar g = 0; g < 4; g++) begin : sw
         binary_mul_seq_param_if #(SW[g]) sb();
         assign sb.a           = s_a[SW[g]-1:0];
         assign sb.b           = s_b[SW[g]-1:0];
         assign sb.signed_mode = s_sm;
         assign sb.in_valid    = s_valid;
         assign sb.out_ready   = 1'b1;
         assign s_ov[g]        = sb.out_valid;
         assign s_p[g]         = 32'(sb.p);
         binary_mul_seq_param #(.WIDTH(SW[g]), .BPC(SB[g])) d(.clk(clk), .rst(rst), .en_i(1'b1), .bus(sb));
      end
   endgenerate

   logic [29:0] exp_q[$];
   logic [31:0] sq[4][$];

   function automatic logic [63:0] ref_f(input logic [63:0] a, input logic [63:0] b, input logic sm, input int w);
      longint xa, xb;
      logic [63:0] mk;
      mk = (64'd1 << w) - 64'd1;
      xa = longint'(a & mk);
      xb = longint'(b & mk);
      if (sm && xa[w-1]) xa = xa - longint'(64'd1 << w);
      if (sm && xb[w-1]) xb = xb - longint'(64'd1 << w);
      return 64'(xa * xb) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   task automatic run(input logic [14:0] a, input logic [14:0] b, input logic sm, input logic tog,
                      output int lat, output logic [29:0] got, output logic [29:0] exp);
      @(negedge clk);
      m.a = a; m.b = b; m.signed_mode = sm; m.in_valid = 1'b1;
      exp_q.push_back(30'(ref_f(64'(a), 64'(b), sm, 15)));
      @(negedge clk);
      m.in_valid = 1'b0; m.a = ~a; m.b = ~b; m.signed_mode = ~sm;
      lat = 0;
      while (!m.out_valid && lat < 200) begin
         if (tog) en = lat[0];
         @(negedge clk);
         lat++;
      end
      en  = 1'b1;
      got = m.p;
      exp = exp_q.pop_front();
   endtask

   task automatic test_reset();
      @(negedge clk);
      nchk++; if (m.in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b exp 0", m.in_ready); end
      nchk++; if (m.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b exp 0", m.out_valid); end
      nchk++; if (m.p !== 30'd0) begin nerr++; $display("FAIL reset_p: got %0d exp 0", m.p); end
      rst = 1'b0;
      #1;
      nchk++; if (m.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_release_in_ready: got %b exp 1", m.in_ready); end
   endtask

   task automatic test_zero();
      int lat; logic [29:0] got, exp;
      run(15'd0, 15'd0, 1'b0, 1'b0, lat, got, exp);
      nchk++; if (lat != 15) begin nerr++; $display("FAIL zero_latency: got %0d exp 15", lat); end
      nchk++; if (got !== exp || got !== 30'd0) begin nerr++; $display("FAIL zero_product: got %0d exp 0", got); end
   endtask

   task automatic test_unsigned_max();
      int lat; logic [29:0] got, exp;
      run(15'd32767, 15'd32767, 1'b0, 1'b0, lat, got, exp);
      nchk++; if (lat != 15) begin nerr++; $display("FAIL umax_latency: got %0d exp 15", lat); end
      nchk++; if (got !== exp || got !== 30'd1073676289) begin nerr++; $display("FAIL umax_product: got %0d exp 1073676289", got); end
   endtask

   task automatic test_bpc4();
      int lat;
      @(negedge clk);
      m4.a = 15'd32767; m4.b = 15'd32767; m4.signed_mode = 1'b0; m4.in_valid = 1'b1;
      @(negedge clk);
      m4.in_valid = 1'b0;
      lat = 0;
      while (!m4.out_valid && lat < 100) begin @(negedge clk); lat++; end
      nchk++; if (lat != 4) begin nerr++; $display("FAIL bpc4_latency: got %0d exp 4", lat); end
      nchk++; if (m4.p !== 30'd1073676289) begin nerr++; $display("FAIL bpc4_umax: got %0d exp 1073676289", m4.p); end
      @(negedge clk);
      m4.a = 15'h4000; m4.b = 15'h3fff; m4.signed_mode = 1'b1; m4.in_valid = 1'b1;
      @(negedge clk);
      m4.in_valid = 1'b0;
      lat = 0;
      while (!m4.out_valid && lat < 100) begin @(negedge clk); lat++; end
      nchk++; if (lat != 4) begin nerr++; $display("FAIL bpc4_signed_latency: got %0d exp 4", lat); end
      nchk++; if (m4.p !== 30'd805322752) begin nerr++; $display("FAIL bpc4_signed: got %0d exp 805322752", m4.p); end
   endtask

   task automatic test_signed();
      int lat; logic [29:0] got, exp;
      run(15'h4000, 15'h7fff, 1'b1, 1'b0, lat, got, exp);
      nchk++; if (got !== exp || got !== 30'd16384) begin nerr++; $display("FAIL signed_min_x_m1: got %0d exp 16384", got); end
      run(15'h4000, 15'h3fff, 1'b1, 1'b0, lat, got, exp);
      nchk++; if (got !== exp || got !== 30'd805322752) begin nerr++; $display("FAIL signed_min_x_max: got %0d exp 805322752", got); end
      run(15'h4000, 15'h4000, 1'b1, 1'b0, lat, got, exp);
      nchk++; if (got !== exp || got !== 30'd268435456) begin nerr++; $display("FAIL signed_min_x_min: got %0d exp 268435456", got); end
      run(15'h7ffd, 15'd7, 1'b1, 1'b0, lat, got, exp);
      nchk++; if (got !== exp) begin nerr++; $display("FAIL signed_m3_x_7: got %0d exp %0d", got, exp); end
   endtask

   task automatic test_back_to_back();
      logic [14:0] pa[3], pb[3];
      int lat; logic [29:0] e;
      pa = '{15'd3, 15'd1234, 15'h7abc};
      pb = '{15'd5, 15'd4321, 15'h0042};
      @(negedge clk);
      m.a = pa[0]; m.b = pb[0]; m.signed_mode = 1'b0; m.in_valid = 1'b1;
      exp_q.push_back(30'(ref_f(64'(pa[0]), 64'(pb[0]), 1'b0, 15)));
      @(negedge clk);
      m.a = pa[1]; m.b = pb[1];
      exp_q.push_back(30'(ref_f(64'(pa[1]), 64'(pb[1]), 1'b0, 15)));
      for (int k = 0; k < 3; k++) begin
         lat = 0;
         while (!m.out_valid && lat < 100) begin
            nchk++; if (m.in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_busy_in_ready: got %b exp 0", m.in_ready); end
            @(negedge clk);
            lat++;
         end
         nchk++; if (lat != 15) begin nerr++; $display("FAIL b2b_latency_%0d: got %0d exp 15", k, lat); end
         e = exp_q.pop_front();
         nchk++; if (m.p !== e) begin nerr++; $display("FAIL b2b_product_%0d: got %0d exp %0d", k, m.p, e); end
         nchk++; if (m.in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_done_in_ready_%0d: got %b exp 1", k, m.in_ready); end
         if (k == 2) m.in_valid = 1'b0;
         @(negedge clk);
         if (k == 0) begin
            m.a = pa[2]; m.b = pb[2];
            exp_q.push_back(30'(ref_f(64'(pa[2]), 64'(pb[2]), 1'b0, 15)));
         end
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [29:0] e;
      m.out_ready = 1'b0;
      @(negedge clk);
      m.a = 15'h7fff; m.b = 15'h7fff; m.signed_mode = 1'b1; m.in_valid = 1'b1;
      exp_q.push_back(30'(ref_f(64'h7fff, 64'h7fff, 1'b1, 15)));
      @(negedge clk);
      m.in_valid = 1'b0;
      lat = 0;
      while (!m.out_valid && lat < 100) begin @(negedge clk); lat++; end
      e = exp_q.pop_front();
      m.a = 15'd9; m.b = 15'd9; m.in_valid = 1'b1;
      repeat (10) begin
         nchk++;
         if (m.out_valid !== 1'b1 || m.p !== e || m.in_ready !== 1'b0 || e !== 30'd1) begin
            nerr++; $display("FAIL backpressure_hold: ov=%b p=%0d rdy=%b exp ov=1 p=1 rdy=0", m.out_valid, m.p, m.in_ready);
         end
         @(negedge clk);
      end
      m.in_valid = 1'b0;
      m.out_ready = 1'b1;
      @(negedge clk);
      nchk++; if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1) begin
         nerr++; $display("FAIL backpressure_release: ov=%b rdy=%b exp ov=0 rdy=1", m.out_valid, m.in_ready);
      end
   endtask

   task automatic test_en_toggle();
      int lat; logic [29:0] got, exp;
      run(15'd12345, 15'd321, 1'b0, 1'b1, lat, got, exp);
      nchk++; if (lat != 30) begin nerr++; $display("FAIL en_toggle_latency: got %0d exp 30", lat); end
      nchk++; if (got !== exp) begin nerr++; $display("FAIL en_toggle_product: got %0d exp %0d", got, exp); end
   endtask

   task automatic test_rst_mid_busy();
      logic bad;
      @(negedge clk);
      m.a = 15'd100; m.b = 15'd200; m.signed_mode = 1'b0; m.in_valid = 1'b1;
      @(negedge clk);
      m.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      nchk++; if (m.in_ready !== 1'b0 || m.out_valid !== 1'b0) begin
         nerr++; $display("FAIL rst_mid_busy_asserted: rdy=%b ov=%b exp 0 0", m.in_ready, m.out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1) bad = 1'b1;
      end
      nchk++; if (bad !== 1'b0) begin nerr++; $display("FAIL rst_mid_busy_after: got bad=%b exp 0", bad); end
   endtask

   task automatic test_random_main();
      int lat; logic [29:0] got, exp;
      for (int t = 0; t < 8; t++) begin
         run(15'($urandom), 15'($urandom), 1'($urandom), 1'b0, lat, got, exp);
         nchk++; if (got !== exp || lat != 15) begin
            nerr++; $display("FAIL random_main_%0d: got %0d lat %0d exp %0d lat 15", t, got, lat, exp);
         end
      end
   endtask

   task automatic test_random_sweep();
      logic seen[4];
      int lat[4];
      int n, it;
      logic [31:0] e;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         s_a = 16'($urandom); s_b = 16'($urandom); s_sm = 1'($urandom);
         if (t == 0) begin s_a = 16'h8080; s_b = 16'hffff; s_sm = 1'b1; end
         if (t == 1) begin s_a = 16'hffff; s_b = 16'hffff; s_sm = 1'b0; end
         for (int i = 0; i < 4; i++) begin
            sq[i].push_back(32'(ref_f(64'(s_a), 64'(s_b), s_sm, SW[i])));
            seen[i] = 1'b0;
            lat[i] = -1;
         end
         s_valid = 1'b1;
         @(negedge clk);
         s_valid = 1'b0;
         n = 0;
         while (n < 60) begin
            for (int i = 0; i < 4; i++) begin
               if (s_ov[i] && !seen[i]) begin
                  seen[i] = 1'b1;
                  lat[i] = n;
                  e = sq[i].pop_front();
                  nchk++; if (s_p[i] !== e) begin
                     nerr++; $display("FAIL sweep_w%0d_b%0d_product: got %0d exp %0d", SW[i], SB[i], s_p[i], e);
                  end
               end
            end
            if (seen[0] && seen[1] && seen[2] && seen[3]) break;
            @(negedge clk);
            n++;
         end
         for (int i = 0; i < 4; i++) begin
            it = (SW[i] + SB[i] - 1) / SB[i];
            nchk++; if (!seen[i] || lat[i] != it) begin
               nerr++; $display("FAIL sweep_w%0d_b%0d_latency: got %0d exp %0d", SW[i], SB[i], lat[i], it);
            end
         end
      end
   endtask

   initial begin
      m.in_valid = 1'b0; m.out_ready = 1'b1; m.a = '0; m.b = '0; m.signed_mode = 1'b0;
      m4.in_valid = 1'b0; m4.out_ready = 1'b1; m4.a = '0; m4.b = '0; m4.signed_mode = 1'b0;
      s_a = '0; s_b = '0; s_sm = 1'b0; s_valid = 1'b0;
      test_reset();
      test_zero();
      test_unsigned_max();
      test_bpc4();
      test_signed();
      test_back_to_back();
      test_backpressure();
      test_en_toggle();
      test_rst_mid_busy();
      test_random_main();
      test_random_sweep();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
